// File: rtl/spi_master_multi.sv
// Parametrised SPI master: DATA_W-bit words, NUM_SS active-low selects, per-transfer CPOL/CPHA.
// Optional macro SPI_LSB_FIRST_EN adds a latched lsb_first input; otherwise transfers are MSB first.
module spi_master_multi #(
    parameter int DATA_W  = 8,
    parameter int NUM_SS  = 2,
    parameter int CLK_DIV = 4,
    localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              spi_SCLK,
    output logic              spi_MOSI,
    input  logic              spi_MISO,
    output logic [NUM_SS-1:0] spi_SS_n
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_W = $clog2(2 * DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [DIV_W-1:0]    div_cnt_reg;
    logic [HALF_W-1:0]   half_cnt_reg;
    logic                cpol_reg, cpha_reg;
    logic                sclk_reg, mosi_reg;
    logic [NUM_SS-1:0]   ss_n_reg;
    logic [DATA_W-1:0]   tx_sh_reg, rx_sh_reg, rx_data_reg;
    logic                lsb_in, lsb_reg;

    logic                accept;
    logic                counting;
    logic                div_end, half_last;
    logic                leading, sample_edge, shift_edge;
    logic [NUM_SS-1:0]   ss_dec;
    logic [DATA_W-1:0]   rx_shift_in;

    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // An out-of-range index matches no slave, so every select stays high.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
            assign ss_dec[gi] = (ss_sel != SS_W'(gi));
        end
    endgenerate

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            lsb_reg <= 1'b0;
        end else if (accept) begin
            lsb_reg <= lsb_first;
        end
    end
`else
    assign lsb_in  = 1'b0;
    assign lsb_reg = 1'b0;
`endif

    assign div_end   = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
    assign half_last = (half_cnt_reg == HALF_W'(2 * DATA_W - 1));
    assign counting  = (state_reg == S_SETUP) || (state_reg == S_XFER) || (state_reg == S_HOLD);

    // Even half-period indices end on a leading edge. The final trailing edge of a
    // CPHA=0 transfer does not shift, so MOSI keeps the last data bit afterwards.
    assign leading     = ~half_cnt_reg[0];
    assign sample_edge = leading ^ cpha_reg;
    assign shift_edge  = cpha_reg ? leading : (~leading & ~half_last);
    assign rx_shift_in = lsb_reg ? {spi_MISO, rx_sh_reg[DATA_W-1:1]}
                                 : {rx_sh_reg[DATA_W-2:0], spi_MISO};

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_SETUP;
                end
            end
            S_SETUP: if (div_end) state_next = S_XFER;
            S_XFER:  if (div_end && half_last) state_next = S_HOLD;
            S_HOLD:  if (div_end) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            div_cnt_reg  <= '0;
            half_cnt_reg <= '0;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
            ss_n_reg     <= '1;
            tx_sh_reg    <= '0;
            rx_sh_reg    <= '0;
            rx_data_reg  <= '0;
        end else if (accept) begin
            div_cnt_reg  <= '0;
            half_cnt_reg <= '0;
            cpol_reg     <= cpol;
            cpha_reg     <= cpha;
            sclk_reg     <= cpol;
            ss_n_reg     <= ss_dec;
            rx_sh_reg    <= '0;
            // CPHA=0 presents the first bit for the whole setup period.
            if (!cpha) begin
                mosi_reg  <= head_bit(tx_data, lsb_in);
                tx_sh_reg <= drop_head(tx_data, lsb_in);
            end else begin
                tx_sh_reg <= tx_data;
            end
        end else if (counting) begin
            div_cnt_reg <= div_end ? '0 : div_cnt_reg + DIV_W'(1);
            if ((state_reg == S_XFER) && div_end) begin
                half_cnt_reg <= half_last ? '0 : half_cnt_reg + HALF_W'(1);
                sclk_reg     <= half_last ? cpol_reg : ~sclk_reg;
                if (sample_edge) begin
                    rx_sh_reg <= rx_shift_in;
                end
                if (shift_edge) begin
                    mosi_reg  <= head_bit(tx_sh_reg, lsb_reg);
                    tx_sh_reg <= drop_head(tx_sh_reg, lsb_reg);
                end
            end
            // Leaving HOLD: release selects and publish the word for the done cycle.
            if ((state_reg == S_HOLD) && div_end) begin
                ss_n_reg    <= '1;
                rx_data_reg <= rx_sh_reg;
            end
        end
    end

    assign busy     = (state_reg != S_IDLE);
    assign done     = (state_reg == S_DONE);
    assign rx_data  = rx_data_reg;
    assign spi_SCLK = sclk_reg;
    assign spi_MOSI = mosi_reg;
    assign spi_SS_n = ss_n_reg;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: a 2-slave and a 3-slave instance, loopback and a mode-3 slave model.
module tb_spi_master_multi;

    logic       clk;
    logic       rst;
    logic       start, start3;
    logic [7:0] tx_data, tx3;
    logic       ss_sel;
    logic [1:0] ss_sel3;
    logic       cpol, cpha;
    logic       busy, done, busy3, done3;
    logic [7:0] rx_data, rx3;
    logic       sclk, mosi, miso, sclk3, mosi3;
    logic [1:0] ss_n;
    logic [2:0] ss_n3;
    logic       loop_en;
    logic       slave_miso;
`ifdef SPI_LSB_FIRST_EN
    logic       lsb_first;
`endif

    int         n_cmp, n_bad;
    int         done_cnt;
    int         rise_cnt;
    int         slave_idx;
    logic       slave_en;
    logic [7:0] slave_tx, slave_rx;

    assign miso = loop_en ? mosi : slave_miso;

    spi_master_multi #(.DATA_W(8), .NUM_SS(2), .CLK_DIV(4)) u_dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .start      (start),
        .tx_data    (tx_data),
        .ss_sel     (ss_sel),
        .cpol       (cpol),
        .cpha       (cpha),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first  (lsb_first),
`endif
        .busy       (busy),
        .done       (done),
        .rx_data    (rx_data),
        .spi_SCLK   (sclk),
        .spi_MOSI   (mosi),
        .spi_MISO   (miso),
        .spi_SS_n   (ss_n)
    );

    spi_master_multi #(.DATA_W(8), .NUM_SS(3), .CLK_DIV(4)) u_dut3 (
        .clk_clk    (clk),
        .reset_reset(rst),
        .start      (start3),
        .tx_data    (tx3),
        .ss_sel     (ss_sel3),
        .cpol       (1'b0),
        .cpha       (1'b0),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first  (1'b0),
`endif
        .busy       (busy3),
        .done       (done3),
        .rx_data    (rx3),
        .spi_SCLK   (sclk3),
        .spi_MOSI   (mosi3),
        .spi_MISO   (mosi3),
        .spi_SS_n   (ss_n3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Slave model: samples MOSI on rising SCLK, drives MISO MSB first on falling SCLK.
    always @(posedge sclk) begin
        if (slave_en) begin
            slave_rx = {slave_rx[6:0], mosi};
            rise_cnt++;
        end
    end

    always @(negedge sclk) begin
        if (slave_en && slave_idx >= 0) begin
            slave_miso = slave_tx[slave_idx];
            slave_idx--;
        end
    end

    // Starts a transfer at a negedge and returns at the negedge of the done cycle.
    task automatic do_xfer(input logic [7:0] tx, input logic sel, input logic pol, input logic pha,
                           output int lat, output logic [1:0] ss_and, output logic [1:0] ss_or,
                           output logic [1:0] ss_first, output logic mosi_first, output logic sclk_first);
        tx_data   = tx;
        ss_sel    = sel;
        cpol      = pol;
        cpha      = pha;
        start     = 1'b1;
        slave_idx = 7;
        slave_rx  = 8'h00;
        rise_cnt  = 0;
        @(negedge clk);
        start      = 1'b0;
        lat        = 1;
        ss_first   = ss_n;
        mosi_first = mosi;
        sclk_first = sclk;
        ss_and     = 2'b11;
        ss_or      = 2'b00;
        slave_en   = 1'b1;
        while (done !== 1'b1 && lat < 200) begin
            ss_and = ss_and & ss_n;
            ss_or  = ss_or | ss_n;
            @(negedge clk);
            lat++;
        end
        slave_en = 1'b0;
        $display("xfer tx=%02h sel=%0d mode=%0d%0d latency=%0d rx=%02h slave_rx=%02h rises=%0d",
                 tx, sel, pol, pha, lat, rx_data, slave_rx, rise_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx got=%02h want=00", rx_data); end
        n_cmp++; if (sclk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
        n_cmp++; if (mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi got=%b want=0", mosi); end
        n_cmp++; if (ss_n !== 2'b11) begin n_bad++; $display("FAIL reset_ss got=%b want=11", ss_n); end
        n_cmp++; if (ss_n3 !== 3'b111) begin n_bad++; $display("FAIL reset_ss3 got=%b want=111", ss_n3); end
        rst = 1'b0;
        @(negedge clk);
        $display("xfer reset released");
    endtask

    task automatic test_mode0_loopback();
        int lat;
        logic [1:0] s_and, s_or, s_first;
        logic m_first, c_first;
        loop_en = 1'b1;
        do_xfer(8'hA5, 1'b0, 1'b0, 1'b0, lat, s_and, s_or, s_first, m_first, c_first);
        n_cmp++; if (lat !== 73) begin n_bad++; $display("FAIL m0_latency got=%0d want=73", lat); end
        n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL m0_rx got=%02h want=a5", rx_data); end
        n_cmp++; if (slave_rx !== 8'hA5) begin n_bad++; $display("FAIL m0_mosi_word got=%02h want=a5", slave_rx); end
        n_cmp++; if (rise_cnt !== 8) begin n_bad++; $display("FAIL m0_rises got=%0d want=8", rise_cnt); end
        n_cmp++; if (m_first !== 1'b1) begin n_bad++; $display("FAIL m0_mosi_first got=%b want=1", m_first); end
        n_cmp++; if (c_first !== 1'b0) begin n_bad++; $display("FAIL m0_sclk_idle got=%b want=0", c_first); end
        n_cmp++; if (s_first !== 2'b10) begin n_bad++; $display("FAIL m0_ss_first got=%b want=10", s_first); end
        n_cmp++; if (s_and !== 2'b10 || s_or !== 2'b10) begin n_bad++; $display("FAIL m0_ss_steady got=%b/%b want=10/10", s_and, s_or); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL m0_busy_done got=%b want=1", busy); end
        n_cmp++; if (ss_n !== 2'b11) begin n_bad++; $display("FAIL m0_ss_done got=%b want=11", ss_n); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL m0_after got=%b%b want=00", busy, done); end
        n_cmp++; if (mosi !== 1'b1) begin n_bad++; $display("FAIL m0_mosi_hold got=%b want=1", mosi); end
        n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL m0_rx_hold got=%02h want=a5", rx_data); end
    endtask

    task automatic test_mode3_slave();
        int lat;
        logic [1:0] s_and, s_or, s_first;
        logic m_first, c_first;
        loop_en  = 1'b0;
        slave_tx = 8'h3C;
        do_xfer(8'h96, 1'b0, 1'b1, 1'b1, lat, s_and, s_or, s_first, m_first, c_first);
        n_cmp++; if (lat !== 73) begin n_bad++; $display("FAIL m3_latency got=%0d want=73", lat); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL m3_rx got=%02h want=3c", rx_data); end
        n_cmp++; if (slave_rx !== 8'h96) begin n_bad++; $display("FAIL m3_mosi_word got=%02h want=96", slave_rx); end
        n_cmp++; if (rise_cnt !== 8) begin n_bad++; $display("FAIL m3_rises got=%0d want=8", rise_cnt); end
        n_cmp++; if (c_first !== 1'b1) begin n_bad++; $display("FAIL m3_sclk_before got=%b want=1", c_first); end
        n_cmp++; if (sclk !== 1'b1) begin n_bad++; $display("FAIL m3_sclk_done got=%b want=1", sclk); end
        @(negedge clk);
        n_cmp++; if (sclk !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL m3_idle got=sclk%b busy%b want=sclk1 busy0", sclk, busy); end
        loop_en = 1'b1;
    endtask

    task automatic test_start_ignored();
        int lat;
        logic [1:0] s_and, s_or, s_first;
        logic m_first, c_first;
        loop_en  = 1'b1;
        done_cnt = 0;
        fork
            begin
                repeat (10) @(negedge clk);
                start   = 1'b1;
                tx_data = 8'hFF;
                @(negedge clk);
                start   = 1'b0;
            end
        join_none
        do_xfer(8'h3A, 1'b0, 1'b0, 1'b0, lat, s_and, s_or, s_first, m_first, c_first);
        n_cmp++; if (lat !== 73) begin n_bad++; $display("FAIL ign_latency got=%0d want=73", lat); end
        n_cmp++; if (rx_data !== 8'h3A) begin n_bad++; $display("FAIL ign_rx got=%02h want=3a", rx_data); end
        n_cmp++; if (slave_rx !== 8'h3A) begin n_bad++; $display("FAIL ign_mosi_word got=%02h want=3a", slave_rx); end
        start   = 1'b1;
        tx_data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_done_start got=%b want=0", busy); end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_idle got=%b want=0", busy); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ign_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_ss_sel();
        int lat, lat3;
        logic [1:0] s_and, s_or, s_first;
        logic [2:0] and3;
        logic m_first, c_first;
        loop_en = 1'b1;
        tx3     = 8'h5C;
        ss_sel3 = 2'd3;
        start3  = 1'b1;
        fork
            do_xfer(8'hC6, 1'b1, 1'b0, 1'b0, lat, s_and, s_or, s_first, m_first, c_first);
            begin
                @(negedge clk);
                start3 = 1'b0;
                lat3   = 1;
                and3   = 3'b111;
                while (done3 !== 1'b1 && lat3 < 200) begin
                    and3 = and3 & ss_n3;
                    @(negedge clk);
                    lat3++;
                end
                $display("xfer dut3 tx=5c sel=3 latency=%0d rx=%02h", lat3, rx3);
            end
        join
        n_cmp++; if (s_first !== 2'b01) begin n_bad++; $display("FAIL sel1_first got=%b want=01", s_first); end
        n_cmp++; if (s_and !== 2'b01 || s_or !== 2'b01) begin n_bad++; $display("FAIL sel1_steady got=%b/%b want=01/01", s_and, s_or); end
        n_cmp++; if (lat !== 73) begin n_bad++; $display("FAIL sel1_latency got=%0d want=73", lat); end
        n_cmp++; if (rx_data !== 8'hC6) begin n_bad++; $display("FAIL sel1_rx got=%02h want=c6", rx_data); end
        n_cmp++; if (and3 !== 3'b111) begin n_bad++; $display("FAIL sel3_none got=%b want=111", and3); end
        n_cmp++; if (lat3 !== 73) begin n_bad++; $display("FAIL sel3_latency got=%0d want=73", lat3); end
        n_cmp++; if (rx3 !== 8'h5C) begin n_bad++; $display("FAIL sel3_rx got=%02h want=5c", rx3); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        tx_data = 8'hC3;
        ss_sel  = 1'b0;
        cpol    = 1'b0;
        cpha    = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before got=%b want=1", busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ss_n !== 2'b11) begin n_bad++; $display("FAIL rmid_ss got=%b want=11", ss_n); end
        n_cmp++; if (sclk !== 1'b0) begin n_bad++; $display("FAIL rmid_sclk got=%b want=0", sclk); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rmid_rx got=%02h want=00", rx_data); end
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        repeat (100) @(negedge clk);
        #1;
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL rmid_no_done got=%0d want=0", done_cnt); end
        $display("xfer reset at cycle 30 of tx=c3");
    endtask

`ifdef SPI_LSB_FIRST_EN
    task automatic test_lsb_first();
        int lat;
        logic [1:0] s_and, s_or, s_first;
        logic m_first, c_first;
        loop_en   = 1'b1;
        lsb_first = 1'b1;
        do_xfer(8'h01, 1'b0, 1'b0, 1'b0, lat, s_and, s_or, s_first, m_first, c_first);
        n_cmp++; if (m_first !== 1'b1) begin n_bad++; $display("FAIL lsb_mosi_first got=%b want=1", m_first); end
        n_cmp++; if (rx_data !== 8'h01) begin n_bad++; $display("FAIL lsb_rx got=%02h want=01", rx_data); end
        n_cmp++; if (slave_rx !== 8'h80) begin n_bad++; $display("FAIL lsb_wire_order got=%02h want=80", slave_rx); end
        lsb_first = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        done_cnt   = 0;
        rise_cnt   = 0;
        slave_idx  = 7;
        slave_en   = 1'b0;
        slave_tx   = 8'h00;
        slave_rx   = 8'h00;
        slave_miso = 1'b0;
        loop_en    = 1'b1;
        start      = 1'b0;
        start3     = 1'b0;
        tx_data    = 8'h00;
        tx3        = 8'h00;
        ss_sel     = 1'b0;
        ss_sel3    = 2'd0;
        cpol       = 1'b0;
        cpha       = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        lsb_first  = 1'b0;
`endif
        rst        = 1'b1;
        test_reset();
        test_mode0_loopback();
        test_mode3_slave();
        test_start_ignored();
        test_ss_sel();
        test_reset_mid();
`ifdef SPI_LSB_FIRST_EN
        test_lsb_first();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
